game_event_gen: RTL and testbench

Producer side of the scoreboard event interface. Tracks a single descending row of NBLK blocks and detects ball-vs-block hits, ball loss below the paddle, and the block row reaching the limit line. Drives start, hit_block, endgame_ball and endgame_block with the timing the scoreboard consumes. Sits between the ball/paddle motion logic and the scoreboard, and is evaluated once per frame strobe.

---
 rtl/game_event_gen.sv | 214 +++++++++++++++++++++
 tb/tb_game_event_gen.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/game_event_gen.sv
// game_event_gen
// Producer side of the scoreboard event interface. Tracks one descending row
// of NBLK blocks and evaluates each frame strobe for:
//   - the block row reaching the limit line (terminal)
//   - the ball dropping below the paddle (loss)
//   - the ball hitting a block (hit pulses)
//   - row descent every DESC_FRAMES frames
//
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   tick           one-cycle frame strobe
//   btn_start      debounced start button level; its rising edge is used
//   ball_x/ball_y  ball position
//   paddle_x       paddle left edge
//   start          game-running flag to the scoreboard
//   hit_block      HIT_LEN-cycle pulse per block hit
//   endgame_ball   one-cycle ball-lost pulse
//   endgame_block  row reached the limit line (held until reset)
//   ball_rst       one-cycle request to relaunch the ball
//   block_mask     1 = block present
//   block_y        current row top Y
module game_event_gen #(
  parameter int NBLK        = 8,
  parameter int BLK_W       = 80,
  parameter int BLK_H       = 16,
  parameter int Y0          = 40,
  parameter int DESC_FRAMES = 120,
  parameter int DESC_STEP   = 8,
  parameter int LIMIT_Y     = 400,
  parameter int PADDLE_Y    = 440,
  parameter int PADDLE_W    = 80,
  parameter int HIT_LEN     = 2,
  parameter int LIVES       = 10
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            tick,
  input  logic            btn_start,
  input  logic [9:0]      ball_x,
  input  logic [9:0]      ball_y,
  input  logic [9:0]      paddle_x,
  output logic            start,
  output logic            hit_block,
  output logic            endgame_ball,
  output logic            endgame_block,
  output logic            ball_rst,
  output logic [NBLK-1:0] block_mask,
  output logic [9:0]      block_y
);

  localparam int FC_W = (DESC_FRAMES > 1) ? $clog2(DESC_FRAMES) : 1;
  localparam int HC_W = $clog2(HIT_LEN + 1);
  localparam int LV_W = $clog2(LIVES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PLAY, S_LOSS, S_WAIT, S_OVER, S_DEAD
  } state_t;

  state_t            state, state_d;
  logic              btn_prev;
  logic [NBLK-1:0]   mask_d;
  logic [9:0]        y_d;
  logic [FC_W-1:0]   frame_cnt, frame_cnt_d;
  logic [LV_W-1:0]   lives, lives_d;
  logic [2:0]        pending, pending_d;
  logic [HC_W-1:0]   hit_cnt, hit_cnt_d;
  logic              ball_rst_d;

  logic              btn_rise;
  logic [10:0]       row_bot;
  logic [10:0]       pad_r;
  logic              limit_hit;
  logic              ball_lost;
  logic [9:0]        col;
  logic              in_row;
  logic [NBLK-1:0]   hit_vec;
  logic [NBLK-1:0]   mask_after;
  logic              hit_inc;
  logic              pulse_go;
  logic              leave_play;

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  assign btn_rise   = btn_start & ~btn_prev;
  assign row_bot    = {1'b0, block_y} + 11'(BLK_H);
  assign pad_r      = {1'b0, paddle_x} + 11'(PADDLE_W);
  assign limit_hit  = row_bot >= 11'(LIMIT_Y);
  assign ball_lost  = (ball_y >= 10'(PADDLE_Y)) &&
                      ((ball_x < paddle_x) || ({1'b0, ball_x} >= pad_r));
  assign col        = ball_x / 10'(BLK_W);
  assign in_row     = (ball_y >= block_y) && ({1'b0, ball_y} < row_bot);

  // One-hot selection of the struck block; columns past the row never match.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NBLK; i++)
      hit_vec[i] = in_row && (col == 10'(i)) && block_mask[i];
  end

  assign mask_after = block_mask & ~hit_vec;

  // Next state and row bookkeeping
  always_comb begin
    state_d     = state;
    mask_d      = block_mask;
    y_d         = block_y;
    frame_cnt_d = frame_cnt;
    lives_d     = lives;
    ball_rst_d  = 1'b0;
    hit_inc     = 1'b0;
    case (state)
      S_IDLE: begin
        if (btn_rise) begin
          state_d    = S_PLAY;
          ball_rst_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (tick) begin
          if (limit_hit) begin
            state_d = S_OVER;
          end else if (ball_lost) begin
            state_d = S_LOSS;
          end else if (|hit_vec) begin
            hit_inc = 1'b1;
            // Clearing the last block starts a fresh wave at the top.
            if (mask_after == '0) begin
              mask_d = '1;
              y_d    = 10'(Y0);
            end else begin
              mask_d = mask_after;
            end
          end else if (frame_cnt == FC_W'(DESC_FRAMES - 1)) begin
            frame_cnt_d = '0;
            y_d         = block_y + 10'(DESC_STEP);
          end else begin
            frame_cnt_d = frame_cnt + FC_W'(1);
          end
        end
      end
      S_LOSS: begin
        lives_d = lives - LV_W'(1);
        state_d = (lives <= LV_W'(1)) ? S_DEAD : S_WAIT;
      end
      S_WAIT: begin
        if (btn_rise) begin
          state_d     = S_PLAY;
          ball_rst_d  = 1'b1;
          frame_cnt_d = '0;
        end
      end
      S_OVER:  state_d = S_OVER;
      S_DEAD:  state_d = S_DEAD;
      default: state_d = S_IDLE;
    endcase
  end

  // Hit pulse generator: a new pulse may start only once hit_cnt is back at
  // zero, which guarantees one low cycle between pulses. A hit arriving on the
  // same cycle as an idle generator starts the pulse immediately.
  assign leave_play = (state_d != S_PLAY);
  assign pulse_go   = (hit_cnt == '0) && ((pending != 3'd0) || hit_inc);

  always_comb begin
    pending_d = pending;
    hit_cnt_d = hit_cnt;
    if (leave_play) begin
      pending_d = 3'd0;
      hit_cnt_d = '0;
    end else begin
      case ({hit_inc, pulse_go})
        2'b10:   pending_d = sat_inc(pending);
        2'b01:   pending_d = pending - 3'd1;
        default: pending_d = pending;
      endcase
      if (pulse_go)
        hit_cnt_d = HC_W'(HIT_LEN);
      else if (hit_cnt != '0)
        hit_cnt_d = hit_cnt - HC_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      btn_prev   <= 1'b0;
      block_mask <= '1;
      block_y    <= 10'(Y0);
      frame_cnt  <= '0;
      lives      <= LV_W'(LIVES);
      pending    <= 3'd0;
      hit_cnt    <= '0;
      ball_rst   <= 1'b0;
    end else begin
      state      <= state_d;
      btn_prev   <= btn_start;
      block_mask <= mask_d;
      block_y    <= y_d;
      frame_cnt  <= frame_cnt_d;
      lives      <= lives_d;
      pending    <= pending_d;
      hit_cnt    <= hit_cnt_d;
      ball_rst   <= ball_rst_d;
    end
  end

  assign start         = (state == S_PLAY) || (state == S_LOSS) || (state == S_OVER);
  assign hit_block     = (hit_cnt != '0);
  assign endgame_ball  = (state == S_LOSS);
  assign endgame_block = (state == S_OVER);

endmodule

// File: tb/tb_game_event_gen.sv
module tb_game_event_gen;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick;
  logic       btn_start;
  logic [9:0] ball_x, ball_y, paddle_x;
  logic       start, hit_block, endgame_ball, endgame_block, ball_rst;
  logic [7:0] block_mask;
  logic [9:0] block_y;

  int checks = 0;
  int errors = 0;

  game_event_gen #(
    .NBLK(8), .BLK_W(80), .BLK_H(16), .Y0(40),
    .DESC_FRAMES(2), .DESC_STEP(180), .LIMIT_Y(400),
    .PADDLE_Y(440), .PADDLE_W(80), .HIT_LEN(2), .LIVES(2)
  ) dut (
    .clock(clock), .reset(reset), .tick(tick), .btn_start(btn_start),
    .ball_x(ball_x), .ball_y(ball_y), .paddle_x(paddle_x),
    .start(start), .hit_block(hit_block), .endgame_ball(endgame_ball),
    .endgame_block(endgame_block), .ball_rst(ball_rst),
    .block_mask(block_mask), .block_y(block_y)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit rst; bit btn; bit tk;
    int bx; int by; int px;
    bit st; bit hb; bit eb; bit ek; bit br;
    int mask; int y;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  task automatic add(input bit rst, input bit btn, input bit tk,
                     input int bx, input int by, input int px,
                     input bit st, input bit hb, input bit eb, input bit ek,
                     input bit br, input int mask, input int y);
    vec_t v;
    v.rst = rst; v.btn = btn; v.tk = tk;
    v.bx = bx; v.by = by; v.px = px;
    v.st = st; v.hb = hb; v.eb = eb; v.ek = ek; v.br = br;
    v.mask = mask; v.y = y;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, req, req);
    end
  endtask

  initial begin
    vec_t e;
    int run, pulses, bad_len;

    reset = 1'b1; tick = 1'b0; btn_start = 1'b0;
    ball_x = 10'd500; ball_y = 10'd200; paddle_x = 10'd0;

    //   rst btn tk  bx   by   px   st hb eb ek br mask  y
    add(1, 0, 0, 500, 200,   0,  0, 0, 0, 0, 0, 'hFF,  40); // 0 reset
    add(0, 0, 0, 500, 200,   0,  0, 0, 0, 0, 0, 'hFF,  40); // 1 idle
    add(0, 1, 0, 500, 200,   0,  1, 0, 0, 0, 1, 'hFF,  40); // 2 start edge
    add(0, 1, 1,  85,  45,   0,  1, 1, 0, 0, 0, 'hFD,  40); // 3 hit col1
    add(0, 1, 0, 500, 200,   0,  1, 1, 0, 0, 0, 'hFD,  40); // 4
    add(0, 1, 0, 500, 200,   0,  1, 0, 0, 0, 0, 'hFD,  40); // 5
    add(0, 1, 1,   5,  45,   0,  1, 1, 0, 0, 0, 'hFC,  40); // 6 hit col0
    add(0, 1, 1, 165,  45,   0,  1, 1, 0, 0, 0, 'hF8,  40); // 7 hit col2
    add(0, 1, 1, 245,  45,   0,  1, 0, 0, 0, 0, 'hF0,  40); // 8 hit col3
    add(0, 1, 0, 500, 200,   0,  1, 1, 0, 0, 0, 'hF0,  40); // 9
    add(0, 1, 0, 500, 200,   0,  1, 1, 0, 0, 0, 'hF0,  40); // 10
    add(0, 1, 0, 500, 200,   0,  1, 0, 0, 0, 0, 'hF0,  40); // 11
    add(0, 1, 0, 500, 200,   0,  1, 1, 0, 0, 0, 'hF0,  40); // 12
    add(0, 1, 0, 500, 200,   0,  1, 1, 0, 0, 0, 'hF0,  40); // 13
    add(0, 1, 0, 500, 200,   0,  1, 0, 0, 0, 0, 'hF0,  40); // 14
    add(0, 1, 0, 500, 200,   0,  1, 0, 0, 0, 0, 'hF0,  40); // 15 pending empty
    add(0, 1, 1, 325,  45,   0,  1, 1, 0, 0, 0, 'hE0,  40); // 16 col4
    add(0, 1, 1, 405,  45,   0,  1, 1, 0, 0, 0, 'hC0,  40); // 17 col5
    add(0, 1, 1, 485,  45,   0,  1, 0, 0, 0, 0, 'h80,  40); // 18 col6
    add(0, 1, 1, 565,  45,   0,  1, 1, 0, 0, 0, 'hFF,  40); // 19 col7 -> refill
    add(0, 1, 0, 500, 200,   0,  1, 1, 0, 0, 0, 'hFF,  40); // 20
    add(0, 1, 0, 500, 200,   0,  1, 0, 0, 0, 0, 'hFF,  40); // 21
    add(0, 1, 0, 500, 200,   0,  1, 1, 0, 0, 0, 'hFF,  40); // 22
    add(0, 1, 0, 500, 200,   0,  1, 1, 0, 0, 0, 'hFF,  40); // 23
    add(0, 1, 0, 500, 200,   0,  1, 0, 0, 0, 0, 'hFF,  40); // 24
    add(0, 1, 0, 500, 200,   0,  1, 1, 0, 0, 0, 'hFF,  40); // 25 pulse 8 starts
    add(1, 0, 0, 500, 200,   0,  0, 0, 0, 0, 0, 'hFF,  40); // 26 reset mid-pulse
    add(0, 0, 0, 500, 200,   0,  0, 0, 0, 0, 0, 'hFF,  40); // 27
    add(0, 1, 0, 500, 200,   0,  1, 0, 0, 0, 1, 'hFF,  40); // 28 start
    add(0, 1, 1,   5,  45,   0,  1, 1, 0, 0, 0, 'hFE,  40); // 29 hit col0
    add(0, 1, 1, 100, 445, 200,  1, 0, 1, 0, 0, 'hFE,  40); // 30 loss, pulse cut
    add(0, 1, 0, 500, 200,   0,  0, 0, 0, 0, 0, 'hFE,  40); // 31 WAIT
    add(0, 1, 1,  85,  45,   0,  0, 0, 0, 0, 0, 'hFE,  40); // 32 tick ignored
    add(0, 0, 0, 500, 200,   0,  0, 0, 0, 0, 0, 'hFE,  40); // 33
    add(0, 1, 0, 500, 200,   0,  1, 0, 0, 0, 1, 'hFE,  40); // 34 resume
    add(0, 1, 1, 279, 445, 200,  1, 0, 0, 0, 0, 'hFE,  40); // 35 paddle right edge
    add(0, 1, 1, 280, 445, 200,  1, 0, 1, 0, 0, 'hFE,  40); // 36 just past paddle
    add(0, 1, 0, 500, 200,   0,  0, 0, 0, 0, 0, 'hFE,  40); // 37 DEAD
    add(0, 0, 0, 500, 200,   0,  0, 0, 0, 0, 0, 'hFE,  40); // 38
    add(0, 1, 0, 500, 200,   0,  0, 0, 0, 0, 0, 'hFE,  40); // 39 start ignored
    add(0, 1, 1,  85,  45,   0,  0, 0, 0, 0, 0, 'hFE,  40); // 40 tick ignored
    add(1, 0, 0, 500, 200,   0,  0, 0, 0, 0, 0, 'hFF,  40); // 41 reset
    add(0, 0, 0, 500, 200,   0,  0, 0, 0, 0, 0, 'hFF,  40); // 42
    add(0, 1, 0, 500, 200,   0,  1, 0, 0, 0, 1, 'hFF,  40); // 43 start
    add(0, 1, 1, 500,  56,   0,  1, 0, 0, 0, 0, 'hFF,  40); // 44 just below row
    add(0, 1, 1, 500, 200,   0,  1, 0, 0, 0, 0, 'hFF, 220); // 45 descend
    add(0, 1, 1, 700, 225,   0,  1, 0, 0, 0, 0, 'hFF, 220); // 46 col 8 outside
    add(0, 1, 1, 500, 200,   0,  1, 0, 0, 0, 0, 'hFF, 400); // 47 descend
    add(0, 1, 1,   5, 405,   0,  1, 0, 0, 1, 0, 'hFF, 400); // 48 limit beats hit
    add(0, 1, 0, 500, 200,   0,  1, 0, 0, 1, 0, 'hFF, 400); // 49
    add(0, 0, 0, 500, 200,   0,  1, 0, 0, 1, 0, 'hFF, 400); // 50
    add(0, 1, 1,   5, 405,   0,  1, 0, 0, 1, 0, 'hFF, 400); // 51 still over
    add(1, 0, 0, 500, 200,   0,  0, 0, 0, 0, 0, 'hFF,  40); // 52 reset
    add(0, 0, 0, 500, 200,   0,  0, 0, 0, 0, 0, 'hFF,  40); // 53

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clock);
      reset     = tbl[i].rst;
      btn_start = tbl[i].btn;
      tick      = tbl[i].tk;
      ball_x    = 10'(tbl[i].bx);
      ball_y    = 10'(tbl[i].by);
      paddle_x  = 10'(tbl[i].px);
      exp_q.push_back(tbl[i]);
      @(posedge clock);
      #1;
      e = exp_q.pop_front();
      check($sformatf("v%0d.start", i),         int'(start),         int'(e.st));
      check($sformatf("v%0d.hit_block", i),     int'(hit_block),     int'(e.hb));
      check($sformatf("v%0d.endgame_ball", i),  int'(endgame_ball),  int'(e.eb));
      check($sformatf("v%0d.endgame_block", i), int'(endgame_block), int'(e.ek));
      check($sformatf("v%0d.ball_rst", i),      int'(ball_rst),      int'(e.br));
      check($sformatf("v%0d.block_mask", i),    int'(block_mask),    e.mask);
      check($sformatf("v%0d.block_y", i),       int'(block_y),       e.y);
    end

    // Three back-to-back hit ticks: three separate 2-cycle pulses.
    @(negedge clock);
    btn_start = 1'b1; tick = 1'b0;
    @(posedge clock);
    #1;
    check("seq.ball_rst", int'(ball_rst), 1);
    run = 0; pulses = 0; bad_len = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clock);
      tick   = (c < 3);
      ball_x = 10'(5 + 80 * c);
      ball_y = (c < 3) ? 10'd45 : 10'd200;
      @(posedge clock);
      #1;
      if (hit_block) begin
        run++;
      end else if (run > 0) begin
        pulses++;
        if (run != 2) bad_len++;
        run = 0;
      end
    end
    tick = 1'b0;
    check("seq.pulse_count", pulses, 3);
    check("seq.pulse_len", bad_len, 0);
    check("seq.hit_idle", int'(hit_block), 0);
    check("seq.block_mask", int'(block_mask), 'hF8);
    check("seq.block_y", int'(block_y), 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
